// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared register-index definitions for the integer register
//               file and its pending-write scoreboard.
//               REG_AW     - architectural register index width
//               reg_idx_t  - register index type
//               NREGS_I/E  - RV32I / RV32E register counts
//               reg_live() - 1 when an index names a real, writable register
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int REG_AW  = 5;
    localparam int NREGS_I = 32;
    localparam int NREGS_E = 16;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // x0 is hardwired to zero.
    // On RV32E every index with the top bit set is out of range.
    function automatic logic reg_live(input reg_idx_t idx, input int nregs);
        return (idx != '0) && ((nregs == NREGS_I) || !idx[REG_AW-1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Per-register pending-write scoreboard. Each live register has
//               a saturating counter that issue increments (sb_set) and each
//               enabled write port targeting it decrements.
// Ports       : clk, rst_n           - clock, async active-low reset
//               wr_en/wr_addr        - writeback ports (decrement)
//               rs_addr -> rs_busy   - per read port busy flag
//               sb_set/sb_addr       - issue-side increment request
//               sb_ready             - 0 when sb_addr counter is saturated
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import rv_pkg::*;
#(
    parameter int NREGS  = NREGS_I,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*REG_AW-1:0] wr_addr,
    input  logic [NREAD*REG_AW-1:0]  rs_addr,
    input  logic                     sb_set,
    input  reg_idx_t                 sb_addr,
    output logic [NREAD-1:0]         rs_busy,
    output logic                     sb_ready
);

    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;
    localparam logic [PEND_W:0]   c_ONE      = {{PEND_W{1'b0}}, 1'b1};

    // Flat 32-entry views so any 5-bit index selects safely; x0 and
    // out-of-range entries are constant (never busy, never full).
    logic [31:0] w_busy_vec;
    logic [31:0] w_full_vec;
    logic [31:0] w_under_vec;
    logic        w_underflow;

    genvar gr;
    genvar gk;

    generate
        for (gr = 0; gr < 32; gr++) begin : g_reg
            if ((gr == 0) || (gr >= NREGS)) begin : g_none
                assign w_busy_vec[gr]  = 1'b0;
                assign w_full_vec[gr]  = 1'b0;
                assign w_under_vec[gr] = 1'b0;
            end else begin : g_cnt
                logic [PEND_W-1:0] r_pend;
                logic [PEND_W-1:0] w_sum;
                logic [PEND_W-1:0] w_next;
                logic [PEND_W:0]   w_dec;
                logic              w_inc;
                logic              w_under;

                always_comb begin
                    w_dec = '0;
                    for (int p = 0; p < NWRITE; p++) begin
                        if (wr_en[p] && (wr_addr[p*REG_AW +: REG_AW] == reg_idx_t'(gr))) begin
                            w_dec = w_dec + c_ONE;
                        end
                    end
                    // Increment is gated by saturation, so w_sum cannot wrap.
                    w_inc   = sb_set && (sb_addr == reg_idx_t'(gr)) && (r_pend != c_PEND_MAX);
                    w_sum   = r_pend + {{(PEND_W-1){1'b0}}, w_inc};
                    w_under = (w_dec > {1'b0, w_sum});
                    w_next  = w_under ? '0 : (w_sum - w_dec[PEND_W-1:0]);
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_pend <= '0;
                    end else begin
                        r_pend <= w_next;
                    end
                end

                // With forwarding, a write that retires the last pending
                // producer makes the register usable in the same cycle.
                assign w_busy_vec[gr]  = (r_pend != '0) &&
                                         !((BYPASS != 0) && (w_dec != '0) && (w_next == '0));
                assign w_full_vec[gr]  = (r_pend == c_PEND_MAX);
                assign w_under_vec[gr] = w_under;
            end
        end

        for (gk = 0; gk < NREAD; gk++) begin : g_busy
            assign rs_busy[gk] = w_busy_vec[rs_addr[gk*REG_AW +: REG_AW]];
        end
    endgenerate

    assign sb_ready    = !w_full_vec[sb_addr];
    assign w_underflow = |w_under_vec;

    // Writeback without a matching outstanding issue is a protocol error.
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !w_underflow);

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port integer register file with optional
//               write-to-read forwarding and a pending-write scoreboard.
// Ports       : clk, rst_n           - clock, async active-low reset
//               wr_en/wr_addr/wr_data- NWRITE write ports (higher index wins)
//               rs_addr -> rs_data   - NREAD combinational read ports
//               rs_busy              - source has an outstanding write
//               sb_set/sb_addr       - issue marks an in-flight write
//               sb_ready             - 0 = issue must stall for sb_addr
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = NREGS_I,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*REG_AW-1:0] wr_addr,
    input  logic [NWRITE*XLEN-1:0]   wr_data,
    input  logic [NREAD*REG_AW-1:0]  rs_addr,
    output logic [NREAD*XLEN-1:0]    rs_data,
    output logic [NREAD-1:0]         rs_busy,
    input  logic                     sb_set,
    input  reg_idx_t                 sb_addr,
    output logic                     sb_ready
);

    // Read view of all 32 indices; x0 and out-of-range entries read zero.
    logic [31:0][XLEN-1:0] w_rd_vec;

    genvar gr;
    genvar gk;

    generate
        for (gr = 0; gr < 32; gr++) begin : g_reg
            if ((gr == 0) || (gr >= NREGS)) begin : g_zero
                assign w_rd_vec[gr] = '0;
            end else begin : g_live
                logic [XLEN-1:0] r_q;
                logic [XLEN-1:0] w_wd;

                // Ascending scan: the highest-numbered matching port wins.
                always_comb begin
                    w_wd = r_q;
                    for (int p = 0; p < NWRITE; p++) begin
                        if (wr_en[p] && (wr_addr[p*REG_AW +: REG_AW] == reg_idx_t'(gr))) begin
                            w_wd = wr_data[p*XLEN +: XLEN];
                        end
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_wd;
                    end
                end

                assign w_rd_vec[gr] = r_q;
            end
        end

        for (gk = 0; gk < NREAD; gk++) begin : g_rd
            reg_idx_t        w_ra;
            logic [XLEN-1:0] w_rd;

            assign w_ra = rs_addr[gk*REG_AW +: REG_AW];

            always_comb begin
                w_rd = w_rd_vec[w_ra];
                if ((BYPASS != 0) && reg_live(w_ra, NREGS)) begin
                    for (int p = 0; p < NWRITE; p++) begin
                        if (wr_en[p] && (wr_addr[p*REG_AW +: REG_AW] == w_ra)) begin
                            w_rd = wr_data[p*XLEN +: XLEN];
                        end
                    end
                end
            end

            assign rs_data[gk*XLEN +: XLEN] = w_rd;
        end
    endgenerate

    regfile_sb #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .BYPASS (BYPASS),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rs_addr  (rs_addr),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .rs_busy  (rs_busy),
        .sb_ready (sb_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Instance u_dut_a is the
//               RV32I, 2-write, forwarding configuration; u_dut_e is RV32E,
//               1-write, no forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- instance A: NREGS=32, NWRITE=2, BYPASS=1 ----------------
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic [9:0]  a_rs_addr;
    logic [63:0] a_rs_data;
    logic [1:0]  a_rs_busy;
    logic        a_sb_set;
    logic [4:0]  a_sb_addr;
    logic        a_sb_ready;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1), .PEND_W(2)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
        .sb_set(a_sb_set), .sb_addr(a_sb_addr), .sb_ready(a_sb_ready)
    );

    // ---------------- instance E: NREGS=16, NWRITE=1, BYPASS=0 ----------------
    logic [0:0]  e_wr_en;
    logic [4:0]  e_wr_addr;
    logic [31:0] e_wr_data;
    logic [9:0]  e_rs_addr;
    logic [63:0] e_rs_data;
    logic [1:0]  e_rs_busy;
    logic        e_sb_set;
    logic [4:0]  e_sb_addr;
    logic        e_sb_ready;

    regfile_mp #(
        .XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(1), .BYPASS(0), .PEND_W(2)
    ) u_dut_e (
        .clk(clk), .rst_n(rst_n),
        .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
        .rs_addr(e_rs_addr), .rs_data(e_rs_data), .rs_busy(e_rs_busy),
        .sb_set(e_sb_set), .sb_addr(e_sb_addr), .sb_ready(e_sb_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        set;
        logic [4:0]  sa;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        er;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic set, input logic [4:0] sa,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic [1:0] eb, input logic er);
        vec_t v;
        v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.set = set; v.sa = sa;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic a_idle();
        a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        a_sb_set = 1'b0; a_sb_addr = '0;
    endtask

    task automatic e_idle();
        e_wr_en = '0; e_wr_addr = '0; e_wr_data = '0;
        e_rs_addr = '0; e_sb_set = 1'b0; e_sb_addr = '0;
    endtask

    // One cycle on instance E: drive, check mid-cycle, take the edge.
    task automatic e_step(input string tag,
        input logic wen, input logic [4:0] wa, input logic [31:0] wd,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic set, input logic [4:0] sa,
        input logic [31:0] x0, input logic [31:0] x1,
        input logic [1:0] xb, input logic xr);
        e_wr_en = wen; e_wr_addr = wa; e_wr_data = wd;
        e_rs_addr = {ra1, ra0}; e_sb_set = set; e_sb_addr = sa;
        @(negedge clk);
        check({tag, ".rd0"},  e_rs_data[31:0],  x0);
        check({tag, ".rd1"},  e_rs_data[63:32], x1);
        check({tag, ".busy"}, {30'd0, e_rs_busy}, {30'd0, xb});
        check({tag, ".rdy"},  {31'd0, e_sb_ready}, {31'd0, xr});
        @(posedge clk); #1;
        e_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] ra;

        // Table for instance A; state starts from reset.
        //            wen    wa0    wd0            wa1    wd1            ra0    ra1    set   sa     e0             e1             eb     er
        tbl[0]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd5,  1'b0, 5'd0,  32'h0,         32'h0,         2'b00, 1'b1);
        tbl[1]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd0,  1'b1, 5'd3,  32'h0,         32'h0,         2'b00, 1'b1);
        tbl[2]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd0,  1'b1, 5'd3,  32'h0,         32'h0,         2'b01, 1'b1);
        tbl[3]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd0,  1'b1, 5'd3,  32'h0,         32'h0,         2'b01, 1'b1);
        tbl[4]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd0,  1'b1, 5'd3,  32'h0,         32'h0,         2'b01, 1'b0);
        tbl[5]  = mk(2'b01, 5'd3,  32'h33,        5'd0,  32'h0,         5'd3,  5'd0,  1'b0, 5'd3,  32'h33,        32'h0,         2'b01, 1'b0);
        tbl[6]  = mk(2'b01, 5'd3,  32'h34,        5'd0,  32'h0,         5'd3,  5'd0,  1'b0, 5'd3,  32'h34,        32'h0,         2'b01, 1'b1);
        tbl[7]  = mk(2'b01, 5'd3,  32'h35,        5'd0,  32'h0,         5'd3,  5'd3,  1'b0, 5'd3,  32'h35,        32'h35,        2'b00, 1'b1);
        tbl[8]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd3,  1'b0, 5'd3,  32'h35,        32'h35,        2'b00, 1'b1);
        tbl[9]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd3,  1'b1, 5'd5,  32'h0,         32'h35,        2'b00, 1'b1);
        tbl[10] = mk(2'b11, 5'd5,  32'h11111111,  5'd5,  32'h22222222,  5'd5,  5'd5,  1'b1, 5'd5,  32'h22222222,  32'h22222222,  2'b00, 1'b1);
        tbl[11] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd5,  1'b0, 5'd5,  32'h22222222,  32'h22222222,  2'b00, 1'b1);
        tbl[12] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd5,  1'b1, 5'd9,  32'h0,         32'h22222222,  2'b00, 1'b1);
        tbl[13] = mk(2'b01, 5'd9,  32'h99,        5'd0,  32'h0,         5'd9,  5'd9,  1'b1, 5'd9,  32'h99,        32'h99,        2'b11, 1'b1);
        tbl[14] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd9,  1'b0, 5'd9,  32'h99,        32'h99,        2'b11, 1'b1);
        tbl[15] = mk(2'b10, 5'd0,  32'h0,         5'd9,  32'h9A,        5'd9,  5'd9,  1'b0, 5'd9,  32'h9A,        32'h9A,        2'b00, 1'b1);
        tbl[16] = mk(2'b01, 5'd0,  32'hFFFFFFFF,  5'd0,  32'h0,         5'd0,  5'd9,  1'b1, 5'd0,  32'h0,         32'h9A,        2'b00, 1'b1);
        tbl[17] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd9,  1'b0, 5'd0,  32'h0,         32'h9A,        2'b00, 1'b1);
        tbl[18] = mk(2'b01, 5'd7,  32'hA5A5A5A5,  5'd0,  32'h0,         5'd7,  5'd3,  1'b1, 5'd7,  32'hA5A5A5A5,  32'h35,        2'b00, 1'b1);
        tbl[19] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd3,  1'b0, 5'd7,  32'hA5A5A5A5,  32'h35,        2'b00, 1'b1);
        tbl[20] = mk(2'b10, 5'd8,  32'hBAD,       5'd8,  32'h88,        5'd8,  5'd7,  1'b1, 5'd8,  32'h88,        32'hA5A5A5A5,  2'b00, 1'b1);
        tbl[21] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd8,  5'd7,  1'b0, 5'd8,  32'h88,        32'hA5A5A5A5,  2'b00, 1'b1);

        rst_n = 1'b0;
        a_idle(); a_rs_addr = '0;
        e_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven vectors on A ----------------
        for (int i = 0; i < NV; i++) begin
            a_wr_en   = tbl[i].wen;
            a_wr_addr = {tbl[i].wa1, tbl[i].wa0};
            a_wr_data = {tbl[i].wd1, tbl[i].wd0};
            a_rs_addr = {tbl[i].ra1, tbl[i].ra0};
            a_sb_set  = tbl[i].set;
            a_sb_addr = tbl[i].sa;
            @(negedge clk);
            check($sformatf("a%0d.rd0", i),  a_rs_data[31:0],  tbl[i].e0);
            check($sformatf("a%0d.rd1", i),  a_rs_data[63:32], tbl[i].e1);
            check($sformatf("a%0d.busy", i), {30'd0, a_rs_busy}, {30'd0, tbl[i].eb});
            check($sformatf("a%0d.rdy", i),  {31'd0, a_sb_ready}, {31'd0, tbl[i].er});
            @(posedge clk); #1;
        end
        a_idle();

        // ---------------- fill every register, then reset ----------------
        for (int r = 1; r < 32; r++) begin
            a_wr_en = 2'b01;
            a_wr_addr = {5'd0, 5'(r)};
            a_wr_data = {32'd0, 32'hDEADBEEF};
            a_sb_set = 1'b1;
            a_sb_addr = 5'(r);
            @(posedge clk); #1;
        end
        a_idle();
        a_sb_set = 1'b1; a_sb_addr = 5'd10;
        @(posedge clk); #1;
        a_idle();
        a_rs_addr = {5'd31, 5'd10};
        @(negedge clk);
        check("pre_rst.rd0",  a_rs_data[31:0],  32'hDEADBEEF);
        check("pre_rst.rd1",  a_rs_data[63:32], 32'hDEADBEEF);
        check("pre_rst.busy", {30'd0, a_rs_busy}, 32'd1);
        @(posedge clk); #1;

        // Reset lands mid-cycle while a write to x12 is in flight.
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd12}; a_wr_data = {32'd0, 32'h0BADF00D};
        a_sb_set = 1'b1; a_sb_addr = 5'd12;
        a_rs_addr = {5'd31, 5'd10};
        #2 rst_n = 1'b0;
        #1;
        check("rst_now.rd0",  a_rs_data[31:0],  32'h0);
        check("rst_now.rd1",  a_rs_data[63:32], 32'h0);
        check("rst_now.busy", {30'd0, a_rs_busy}, 32'd0);
        @(posedge clk); #1;
        a_idle();
        for (int r = 0; r < 32; r++) begin
            ra = 5'(r);
            a_rs_addr = {~ra, ra};
            a_sb_addr = ra;
            @(negedge clk);
            check($sformatf("rst_x%0d.rd0", r), a_rs_data[31:0], 32'h0);
            check($sformatf("rst_x%0d.rd1", r), a_rs_data[63:32], 32'h0);
            check($sformatf("rst_x%0d.busy", r), {30'd0, a_rs_busy}, 32'd0);
            check($sformatf("rst_x%0d.rdy", r), {31'd0, a_sb_ready}, 32'd1);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        a_rs_addr = {5'd10, 5'd12}; a_sb_addr = 5'd12;
        @(negedge clk);
        check("post_rst.x12",  a_rs_data[31:0],  32'h0);
        check("post_rst.x10",  a_rs_data[63:32], 32'h0);
        check("post_rst.busy", {30'd0, a_rs_busy}, 32'd0);
        check("post_rst.rdy",  {31'd0, a_sb_ready}, 32'd1);
        @(posedge clk); #1;

        // ---------------- instance E: no forwarding, RV32E range ----------------
        //     tag    wen   wa      wd             ra0    ra1    set   sa     x0             x1      xb     xr
        e_step("e1",  1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd0,  1'b1, 5'd7,  32'h0,         32'h0,  2'b00, 1'b1);
        e_step("e2",  1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 5'd7,  32'hA5A5A5A5,  32'h0,  2'b00, 1'b1);
        e_step("e3",  1'b0, 5'd0,  32'h0,        5'd6,  5'd0,  1'b1, 5'd6,  32'h0,         32'h0,  2'b00, 1'b1);
        e_step("e4",  1'b1, 5'd6,  32'h66,       5'd6,  5'd0,  1'b0, 5'd6,  32'h0,         32'h0,  2'b01, 1'b1);
        e_step("e5",  1'b0, 5'd0,  32'h0,        5'd6,  5'd0,  1'b0, 5'd6,  32'h66,        32'h0,  2'b00, 1'b1);
        e_step("e6",  1'b1, 5'd4,  32'h44,       5'd4,  5'd0,  1'b1, 5'd4,  32'h0,         32'h0,  2'b00, 1'b1);
        e_step("e7",  1'b1, 5'd20, 32'h12345678, 5'd20, 5'd4,  1'b1, 5'd20, 32'h0,         32'h44, 2'b00, 1'b1);
        e_step("e8",  1'b0, 5'd0,  32'h0,        5'd20, 5'd4,  1'b1, 5'd20, 32'h0,         32'h44, 2'b00, 1'b1);
        e_step("e9",  1'b0, 5'd0,  32'h0,        5'd20, 5'd4,  1'b1, 5'd20, 32'h0,         32'h44, 2'b00, 1'b1);
        e_step("e10", 1'b0, 5'd0,  32'h0,        5'd20, 5'd4,  1'b0, 5'd20, 32'h0,         32'h44, 2'b00, 1'b1);
        e_step("e11", 1'b0, 5'd0,  32'h0,        5'd4,  5'd20, 1'b0, 5'd4,  32'h44,        32'h0,  2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the 2-read/1-write RegFile.
- Adds configurable read/write port counts, RV32E/RV32I depth, optional write-to-read bypass, asynchronous clear, and a per-register pending-write scoreboard.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports) of the pipelined core.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count; 32 or 16 only (RV32E).
- NREAD, 2, number of read ports (1..4).
- NWRITE, 1, number of write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.
- PEND_W, 2, width of per-register outstanding-write counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NWRITE  per-port write enable.
- wr_addr  in  NWRITE*5  per-port destination index; port p uses bits [5p+4:5p].
- wr_data  in  NWRITE*XLEN  per-port write data.
- rs_addr  in  NREAD*5  per-port source index.
- rs_data  out  NREAD*XLEN  per-port read data.
- rs_busy  out  NREAD  1 = the source register has an outstanding write.
- sb_set  in  1  issue marks a new in-flight write to sb_addr.
- sb_addr  in  5  destination being issued.
- sb_ready  out  1  0 = counter for sb_addr is saturated, so issue must stall.

Behaviour:
- **Reset:**
  - rst_n low asynchronously clears all registers and all pending counters to 0.
  - rs_data then reads 0, rs_busy = 0, sb_ready = 1.
  - Reset asserted mid-operation discards any in-flight write that cycle.
- **x0:**
  - Always reads 0 and is never busy.
  - Writes and sb_set to x0 are ignored.
- **Address range:**
  - With NREGS=16, any address bit 4 = 1 is out of range.
  - Out-of-range reads return 0 with busy = 0.
  - Out-of-range writes and sets are ignored.
- **Write:**
  - When wr_en[p] is high, wr_data[p] is stored at the rising edge of clk.
  - Write latency is one cycle.
- **Write conflict:** if two ports write the same register in the same cycle, the higher port index wins. The counter is then decremented by 2.
- **Read:**
  - Reads are combinational from the register array.
  - BYPASS=1: if any wr_en[p] matches rs_addr this cycle, rs_data returns that wr_data, with the highest matching port winning. x0 is never bypassed.
  - BYPASS=0: the read returns the old value until after the edge.
- **Scoreboard:**
  - Each register r has a counter pend[r] of PEND_W bits.
  - sb_set && sb_ready increments pend[sb_addr] at the edge.
  - Each enabled write port targeting r decrements pend[r] at the edge.
  - Set and decrement in the same cycle on the same register apply the net result (+1 and -1 give unchanged).
  - Decrement at 0 saturates at 0; this is a protocol error, and an assertion fires in simulation.
  - sb_set while sb_ready = 0 is ignored (no wrap).
- **Busy and ready flags:**
  - rs_busy[k] = (pend[rs_addr[k]] != 0).
  - With BYPASS=1, rs_busy[k] is additionally cleared when a same-cycle write to that register brings pend to 0.
  - sb_ready = (pend[sb_addr] != 2^PEND_W-1); it is combinational and always 1 for x0.

Decomposition:
- Shared package rv_pkg holds:
  - REG_AW = 5.
  - typedef reg_idx_t (logic [4:0]).
  - Constants NREGS_I = 32 and NREGS_E = 16.
- XLEN remains a module parameter.
- One sub-module, regfile_sb: the per-register pending counters with set/clear and saturation. It is instantiated once and exposes rs_busy and sb_ready.
- Storage, write priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset with all regs previously written 0xDEADBEEF, rst_n low between edges -> all rs_data = 0 immediately, before the next edge; all rs_busy = 0.
- NWRITE=2: port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle -> next cycle x5 reads 0x22222222.
- BYPASS=1: write x7=0xA5A5A5A5 with rs_addr[0]=7 in the same cycle -> rs_data[0]=0xA5A5A5A5 that cycle.
  - Repeat with BYPASS=0 -> old value that cycle, new value after the edge.
- Scoreboard:
  - Three sb_set to x3 (PEND_W=2) -> sb_ready = 0 for x3; a fourth set is ignored.
  - Three writes to x3 -> rs_busy goes low only after the third.
- Simultaneous sb_set and write to x9 with pend[9]=1 -> pend stays 1 and rs_busy stays 1.
- NREGS=16: write 0x12345678 to x20 and read x20 -> returns 0; x4 is unaffected; sb_set to x20 is ignored.
